// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
//   Elastic chain of DEPTH register stages, WIDTH bits each, with a
//   valid/ready handshake on both sides. Empty stages are filled from
//   behind, so bubbles collapse while the output is stalled. Sustains one
//   transfer per cycle and never drops or duplicates a word.
// Ports
//   clk        clock, all state on posedge
//   rst_n      synchronous active-low reset
//   flush      synchronous clear, same effect as reset, wins over transfers
//   in_valid   upstream word valid
//   in_ready   chain accepts in_data this cycle
//   in_data    upstream word
//   out_valid  last stage holds a word
//   out_ready  downstream takes out_data this cycle
//   out_data   last stage word
//   occupancy  registered count of valid stages

// One register stage: valid bit plus data word.
module pipe_stage #(
    parameter int              WIDTH  = 4,
    parameter logic [WIDTH-1:0] RSTVAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d_in,
    output logic             v,
    output logic [WIDTH-1:0] d
);
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            v <= 1'b0;
            d <= RSTVAL;
        end else if (load) begin
            v <= 1'b1;
            d <= d_in;
        end else if (drain) begin
            // data is left as-is; only the valid bit clears
            v <= 1'b0;
        end
    end
endmodule

module pipe_reg_chain #(
    parameter int               WIDTH  = 4,
    parameter int               DEPTH  = 3,
    parameter logic [WIDTH-1:0] RSTVAL = '0,
    localparam int              OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);
    logic [DEPTH-1:0]            vld_pipe;  // per-stage valid, 0 = input side
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0][WIDTH-1:0] stage_din;
    logic [DEPTH-1:0]            rdy;       // stage can take a word
    logic [DEPTH-1:0]            rdy_nxt;   // whatever sits downstream of stage i can take
    logic [DEPTH-1:0]            load;
    logic [DEPTH-1:0]            drain;
    logic [DEPTH-1:0]            v_nxt;
    logic [OCC_W-1:0]            occ_nxt;
    logic                        r_acc;

    // Ready ripples from the output back toward the input. A running
    // accumulator keeps the chain inside one block so no vector bit feeds
    // another bit of itself.
    always_comb begin
        rdy       = '0;
        rdy_nxt   = '0;
        load      = '0;
        drain     = '0;
        stage_din = '0;
        r_acc     = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_nxt[i] = r_acc;
            rdy[i]     = !vld_pipe[i] | r_acc;
            r_acc      = rdy[i];
        end
        in_ready     = rdy[0] & !flush;
        load[0]      = in_valid & in_ready;
        stage_din[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            load[i]      = vld_pipe[i-1] & rdy[i];
            stage_din[i] = dat[i-1];
        end
        for (int i = 0; i < DEPTH; i++) begin
            drain[i] = vld_pipe[i] & rdy_nxt[i] & !load[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            pipe_stage #(.WIDTH(WIDTH), .RSTVAL(RSTVAL)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (flush),
                .load  (load[g]),
                .drain (drain[g]),
                .d_in  (stage_din[g]),
                .v     (vld_pipe[g]),
                .d     (dat[g])
            );
        end
    endgenerate

    // Occupancy is kept as its own register, loaded with the popcount of
    // the next valid vector so it changes on the same edge as the stages.
    always_comb begin
        v_nxt   = load | (vld_pipe & ~drain);
        occ_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_nxt = occ_nxt + OCC_W'(v_nxt[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) occupancy <= '0;
        else                 occupancy <= occ_nxt;
    end

    assign out_valid = vld_pipe[DEPTH-1];
    assign out_data  = dat[DEPTH-1];
endmodule

// File: tb/tb_pipe_reg_chain.sv
module tb_pipe_reg_chain;
    localparam int         W   = 4;
    localparam int         D   = 3;
    localparam logic [3:0] RST = 4'hA;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RSTVAL(RST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 0;

    // Reference: words in flight as slot positions (oldest first) plus a
    // scoreboard of their data in FIFO order.
    int           m_pos[$];
    logic [W-1:0] sb[$];
    int           m_cnt = 0;
    logic         m_in_ready;

    // A chain accepts whenever it has a free slot or the output is draining.
    assign m_in_ready = ((m_cnt < D) || out_ready) && !flush;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each edge: oldest word leaves or advances by one,
    // every younger word advances by one but never past the word ahead.
    initial begin : model
        int np[$];
        int lim;
        int p;
        bit acc;
        forever begin
            @(posedge clk);
            if (!rst_n || flush) begin
                m_pos.delete();
                sb.delete();
            end else begin
                acc = in_valid && ((m_pos.size() < D) || out_ready);
                np.delete();
                lim = D - 1;
                for (int k = 0; k < m_pos.size(); k++) begin
                    p = m_pos[k];
                    if (k == 0 && p == D - 1 && out_ready) continue;
                    p = (p + 1 < lim) ? p + 1 : lim;
                    np.push_back(p);
                    lim = p - 1;
                end
                if (acc) begin
                    np.push_back(0);
                    sb.push_back(in_data);
                end
                m_pos = np;
            end
            m_cnt = m_pos.size();
        end
    end

    // Monitor: compares status every cycle and pops the scoreboard on each
    // output transfer the DUT presents.
    initial begin : monitor
        logic exp_ov;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n) begin
                exp_ov = (m_cnt > 0) && (m_pos[0] == D - 1);
                check("occupancy", 32'(occupancy), 32'(m_cnt));
                check("out_valid", 32'(out_valid), 32'(exp_ov));
                check("in_ready",  32'(in_ready),  32'(m_in_ready));
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        check("sb_underflow", 32'(1), 32'(0));
                    end else begin
                        check("out_data", 32'(out_data), 32'(sb[0]));
                        if (out_ready && !flush) void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] dv);
        bit acc = 0;
        int n   = 0;
        in_valid = 1'b1;
        in_data  = dv;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = m_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("send_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        // reset
        step(2);
        rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(RST));
        check("rst_occupancy", 32'(occupancy), 32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        @(posedge clk); #1;

        // stream
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(4'(i));
        step(5);

        // back-pressure: 8 waits upstream while the chain is full
        out_ready = 1'b0;
        send(4'd5); send(4'd6); send(4'd7);
        in_valid = 1'b1;
        in_data  = 4'd8;
        @(negedge clk);
        check("bp_in_ready",  32'(in_ready),  32'(0));
        check("bp_occupancy", 32'(occupancy), 32'(3));
        check("bp_out_data",  32'(out_data),  32'(5));
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(4'd8);
        step(5);

        // bubble collapse
        out_ready = 1'b0;
        send(4'd1);
        step(2);
        send(4'd2);
        step(1);
        @(negedge clk);
        check("bub_occupancy", 32'(occupancy), 32'(2));
        check("bub_out_valid", 32'(out_valid), 32'(1));
        check("bub_in_ready",  32'(in_ready),  32'(1));
        check("bub_out_data",  32'(out_data),  32'(1));
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(5);

        // full pass-through
        out_ready = 1'b0;
        send(4'd3); send(4'd4); send(4'd5);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'd9;
        @(negedge clk);
        check("full_in_ready",  32'(in_ready),  32'(1));
        check("full_out_valid", 32'(out_valid), 32'(1));
        check("full_out_data",  32'(out_data),  32'(3));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("full_occupancy", 32'(occupancy), 32'(3));
        check("full_next_data", 32'(out_data),  32'(4));
        @(posedge clk); #1;
        step(5);

        // flush, then reset, mid-stream
        for (int r = 0; r < 2; r++) begin
            out_ready = 1'b0;
            send(4'd6); send(4'd7);
            in_valid = 1'b1;
            in_data  = 4'd8;
            if (r == 0) flush = 1'b1;
            else        rst_n = 1'b0;
            @(negedge clk);
            if (r == 0) check("flush_in_ready", 32'(in_ready), 32'(0));
            @(posedge clk); #1;
            flush    = 1'b0;
            rst_n    = 1'b1;
            in_valid = 1'b0;
            @(negedge clk);
            check("clr_occupancy", 32'(occupancy), 32'(0));
            check("clr_out_valid", 32'(out_valid), 32'(0));
            check("clr_out_data",  32'(out_data),  32'(RST));
            @(posedge clk); #1;
        end

        // randomized traffic with occasional flush
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step(1);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(8);
        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
